// File: rtl/rs_issue_sched_pkg.sv
// Shared types for the reservation-station issue scheduler and the RS datapath.
package rs_issue_sched_pkg;

    localparam int TAG_W  = 5;
    localparam int NUM_FU = 4;
    localparam int FU_W   = 2;

    typedef enum logic [FU_W-1:0] {
        FU_ALU   = 2'd0,
        FU_LOAD  = 2'd1,
        FU_STORE = 2'd2,
        FU_FP    = 2'd3
    } FU_TYPE;

endpackage

// File: rtl/rs_issue_sched_age_select.sv
// Oldest-ready picker for one FU class: older_i[j][i] set means entry j predates entry i.
module rs_age_select #(
    parameter  int N     = 5,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]          ready_i,
    input  logic [N-1:0][N-1:0]   older_i,
    output logic                  valid_o,
    output logic [IDX_W-1:0]      idx_o
);

    logic [N-1:0] cand;
    logic         any_cand;

    always_comb begin
        cand = ready_i;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && ready_i[j] && older_i[j][i]) begin
                    cand[i] = 1'b0;
                end
            end
        end
    end

    assign any_cand = |cand;
    assign valid_o  = |ready_i;

    // An inconsistent matrix can leave no candidate; fall back to the lowest ready entry.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (any_cand ? cand[i] : ready_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: slot allocation, CDB wakeup, and oldest-ready
// issue per FU class with a per-class lock that holds a stalled request stable.
module rs_issue_sched
    import rs_issue_sched_pkg::*;
#(
    parameter  int NUM_ENTRIES = 5,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          alloc_valid,
    input  FU_TYPE                        alloc_fu,
    input  logic [TAG_W-1:0]              alloc_t1,
    input  logic [TAG_W-1:0]              alloc_t2,
    output logic                          alloc_ready,
    output logic [IDX_W-1:0]              alloc_idx,
    input  logic                          cdb_valid,
    input  logic [TAG_W-1:0]              cdb_tag,
    output logic [NUM_FU-1:0]             issue_valid,
    output logic [NUM_FU-1:0][IDX_W-1:0]  issue_idx,
    input  logic [NUM_FU-1:0]             fu_ready,
    output logic [CNT_W-1:0]              free_count
);

    logic [NUM_ENTRIES-1:0]                   busy_q, busy_d;
    logic [NUM_ENTRIES-1:0][FU_W-1:0]         fu_q, fu_d;
    logic [NUM_ENTRIES-1:0][TAG_W-1:0]        t1_q, t1_d;
    logic [NUM_ENTRIES-1:0][TAG_W-1:0]        t2_q, t2_d;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]  older_q, older_d;
    logic [NUM_FU-1:0]                        lock_v_q, lock_v_d;
    logic [NUM_FU-1:0][IDX_W-1:0]             lock_idx_q, lock_idx_d;

    logic [NUM_ENTRIES-1:0]                   ready;
    logic [NUM_FU-1:0][NUM_ENTRIES-1:0]       class_ready;
    logic [NUM_FU-1:0]                        sel_valid;
    logic [NUM_FU-1:0][IDX_W-1:0]             sel_idx;
    logic [NUM_FU-1:0]                        issue_fire;
    logic                                     alloc_fire;
    logic                                     cdb_hit;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready[i] = busy_q[i] && (t1_q[i] == '0) && (t2_q[i] == '0);
        end
        for (int c = 0; c < NUM_FU; c++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                class_ready[c][i] = ready[i] && (fu_q[i] == FU_W'(c));
            end
        end
    end

    for (genvar c = 0; c < NUM_FU; c++) begin : g_sel
        rs_age_select #(.N(NUM_ENTRIES)) u_sel (
            .ready_i (class_ready[c]),
            .older_i (older_q),
            .valid_o (sel_valid[c]),
            .idx_o   (sel_idx[c])
        );
    end

    // A held lock wins over the picker so a stalled request never changes under the FU.
    always_comb begin
        for (int c = 0; c < NUM_FU; c++) begin
            issue_valid[c] = lock_v_q[c] | sel_valid[c];
            issue_idx[c]   = lock_v_q[c] ? lock_idx_q[c] : sel_idx[c];
            issue_fire[c]  = issue_valid[c] && fu_ready[c];
        end
    end

    always_comb begin
        alloc_ready = 1'b0;
        alloc_idx   = '0;
        free_count  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_ready = 1'b1;
                alloc_idx   = IDX_W'(i);
                free_count  = free_count + CNT_W'(1);
            end
        end
    end

    assign alloc_fire = alloc_valid && alloc_ready;
    assign cdb_hit    = cdb_valid && (cdb_tag != '0);

    always_comb begin
        busy_d     = busy_q;
        fu_d       = fu_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        older_d    = older_q;
        lock_v_d   = lock_v_q;
        lock_idx_d = lock_idx_q;

        for (int c = 0; c < NUM_FU; c++) begin
            if (issue_fire[c]) begin
                lock_v_d[c] = 1'b0;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (issue_idx[c] == IDX_W'(i)) begin
                        busy_d[i] = 1'b0;
                    end
                end
            end else if (issue_valid[c]) begin
                lock_v_d[c]   = 1'b1;
                lock_idx_d[c] = issue_idx[c];
            end
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cdb_hit && busy_q[i]) begin
                if (t1_q[i] == cdb_tag) t1_d[i] = '0;
                if (t2_q[i] == cdb_tag) t2_d[i] = '0;
            end
        end

        // The target slot is free in registered state, so it never collides with an issue free.
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (alloc_fire && (alloc_idx == IDX_W'(k))) begin
                busy_d[k] = 1'b1;
                fu_d[k]   = alloc_fu;
                t1_d[k]   = (cdb_hit && (alloc_t1 == cdb_tag)) ? '0 : alloc_t1;
                t2_d[k]   = (cdb_hit && (alloc_t2 == cdb_tag)) ? '0 : alloc_t2;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    older_d[k][j] = 1'b0;
                    if (j != k) begin
                        older_d[j][k] = busy_q[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= '0;
            fu_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            older_q    <= '0;
            lock_v_q   <= '0;
            lock_idx_q <= '0;
        end else if (flush) begin
            busy_q     <= '0;
            lock_v_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            busy_q     <= busy_d;
            fu_q       <= fu_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            older_q    <= older_d;
            lock_v_q   <= lock_v_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: sequence-number age model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_rs_issue_sched;
    import rs_issue_sched_pkg::*;

    localparam int N = 5;

    logic              clock = 1'b0;
    logic              reset, flush, alloc_valid, cdb_valid;
    FU_TYPE            alloc_fu;
    logic [TAG_W-1:0]  alloc_t1, alloc_t2, cdb_tag;
    logic              alloc_ready;
    logic [2:0]        alloc_idx;
    logic [3:0]        issue_valid, fu_ready;
    logic [3:0][2:0]   issue_idx;
    logic [2:0]        free_count;

    always #5 clock = ~clock;

    rs_issue_sched #(.NUM_ENTRIES(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_fu    (alloc_fu),
        .alloc_t1    (alloc_t1),
        .alloc_t2    (alloc_t2),
        .alloc_ready (alloc_ready),
        .alloc_idx   (alloc_idx),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .fu_ready    (fu_ready),
        .free_count  (free_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: each entry remembers its allocation sequence number; oldest = smallest number.
    bit m_busy[N];
    int m_fu[N], m_t1[N], m_t2[N], m_seq[N];
    int seq_ctr = 0;
    bit m_lv[4];
    int m_li[4];
    bit started = 1'b0;

    bit e_ar;
    int e_ai, e_fc;
    bit e_iv[4];
    int e_ii[4];

    function automatic void model_eval();
        e_ar = 1'b0; e_ai = 0; e_fc = 0;
        for (int i = 0; i < N; i++) begin
            if (!m_busy[i]) begin
                e_fc++;
                if (!e_ar) begin e_ar = 1'b1; e_ai = i; end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (m_lv[c]) begin
                e_iv[c] = 1'b1; e_ii[c] = m_li[c];
            end else begin
                int best = -1;
                for (int i = 0; i < N; i++) begin
                    if (m_busy[i] && m_fu[i] == c && m_t1[i] == 0 && m_t2[i] == 0 &&
                        (best < 0 || m_seq[i] < m_seq[best])) best = i;
                end
                e_iv[c] = (best >= 0);
                e_ii[c] = (best >= 0) ? best : 0;
            end
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            started = 1'b1;
            seq_ctr = 0;
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0; m_fu[i] = 0; m_t1[i] = 0; m_t2[i] = 0; m_seq[i] = 0;
            end
            for (int c = 0; c < 4; c++) begin m_lv[c] = 0; m_li[c] = 0; end
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            for (int c = 0; c < 4; c++) begin m_lv[c] = 0; m_li[c] = 0; end
        end else begin
            model_eval();
            for (int c = 0; c < 4; c++) begin
                if (e_iv[c] && fu_ready[c]) begin
                    m_busy[e_ii[c]] = 0; m_lv[c] = 0;
                end else if (e_iv[c]) begin
                    m_lv[c] = 1; m_li[c] = e_ii[c];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (cdb_valid && cdb_tag != 0 && m_busy[i]) begin
                    if (m_t1[i] == int'(cdb_tag)) m_t1[i] = 0;
                    if (m_t2[i] == int'(cdb_tag)) m_t2[i] = 0;
                end
            end
            if (alloc_valid && e_ar) begin
                m_busy[e_ai] = 1;
                m_fu[e_ai]   = int'(alloc_fu);
                m_t1[e_ai]   = (cdb_valid && cdb_tag != 0 && alloc_t1 == cdb_tag) ? 0 : int'(alloc_t1);
                m_t2[e_ai]   = (cdb_valid && cdb_tag != 0 && alloc_t2 == cdb_tag) ? 0 : int'(alloc_t2);
                m_seq[e_ai]  = seq_ctr;
                seq_ctr++;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            model_eval();
            check("alloc_ready", alloc_ready, e_ar);
            check("alloc_idx", alloc_idx, e_ai);
            check("free_count", free_count, e_fc);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("issue_valid[%0d]", c), issue_valid[c], e_iv[c]);
                check($sformatf("issue_idx[%0d]", c), issue_idx[c], e_ii[c]);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; cdb_valid = 0; flush = 0;
    endtask

    task automatic alloc(input FU_TYPE fu, input int t1, input int t2);
        alloc_valid = 1; alloc_fu = fu;
        alloc_t1 = TAG_W'(t1); alloc_t2 = TAG_W'(t2);
        cdb_valid = 0;
    endtask

    task automatic cdb(input int tag);
        cdb_valid = 1; cdb_tag = TAG_W'(tag);
    endtask

    initial begin
        reset = 1; flush = 0; alloc_valid = 0; alloc_fu = FU_ALU;
        alloc_t1 = 0; alloc_t2 = 0; cdb_valid = 0; cdb_tag = 0; fu_ready = 4'b0000;
        cyc(); cyc();
        reset = 0;
        check("rst alloc_ready", alloc_ready, 1);
        check("rst alloc_idx", alloc_idx, 0);
        check("rst free_count", free_count, 5);
        check("rst issue_valid", issue_valid, 0);

        // Three ALU allocs while the FU stalls, then drain in age order.
        alloc(FU_ALU, 0, 0);  check("alu alloc0", alloc_idx, 0); cyc();
        check("alu first valid", issue_valid[0], 1);
        check("alu first idx", issue_idx[0], 0);
        alloc(FU_ALU, 0, 0);  check("alu alloc1", alloc_idx, 1); cyc();
        alloc(FU_ALU, 0, 0);  check("alu alloc2", alloc_idx, 2); cyc();
        idle(); fu_ready = 4'b0001;
        check("alu issue a", issue_idx[0], 0); cyc();
        check("alu issue b", issue_idx[0], 1); cyc();
        check("alu issue c", issue_idx[0], 2); cyc();
        check("alu drained valid", issue_valid[0], 0);
        check("alu drained free", free_count, 5);

        // Age ordering across a reused slot.
        fu_ready = 4'b0011;
        alloc(FU_LOAD, 6, 0); check("ld alloc0", alloc_idx, 0); cyc();
        alloc(FU_LOAD, 5, 0); cyc();
        alloc(FU_LOAD, 5, 0); cyc();
        idle(); cdb(6); cyc();
        idle();
        check("ld e0 valid", issue_valid[1], 1);
        check("ld e0 idx", issue_idx[1], 0); cyc();
        check("ld free after e0", free_count, 3);
        check("ld reuse idx", alloc_idx, 0);
        alloc(FU_LOAD, 5, 0); cyc();
        idle(); cdb(5); cyc();
        idle();
        check("ld order 1", issue_idx[1], 1); cyc();
        check("ld order 2", issue_idx[1], 2); cyc();
        check("ld order 3", issue_idx[1], 0); cyc();
        check("ld drained", issue_valid[1], 0);

        // Wakeup by a later broadcast, then same-cycle bypass.
        fu_ready = 4'b0001;
        alloc(FU_ALU, 7, 0); cyc();
        idle(); check("wk pending a", issue_valid[0], 0); cyc();
        check("wk pending b", issue_valid[0], 0);
        cdb(7); cyc();
        idle();
        check("wk woke valid", issue_valid[0], 1);
        check("wk woke idx", issue_idx[0], 0); cyc();
        check("wk issued", issue_valid[0], 0);
        alloc(FU_ALU, 7, 0); cdb(7); cyc();
        idle(); check("wk bypass", issue_valid[0], 1); cyc();
        check("wk bypass free", free_count, 5);

        // Lock: FP entry 3 stalls, older FP entry 1 wakes but must wait.
        fu_ready = 4'b0000;
        alloc(FU_ALU, 9, 0); cyc();
        alloc(FU_FP, 4, 0); cyc();
        alloc(FU_ALU, 9, 0); cyc();
        alloc(FU_FP, 0, 0); cyc();
        idle();
        check("lk valid", issue_valid[3], 1);
        check("lk idx", issue_idx[3], 3); cyc();
        cdb(4); cyc();
        idle(); check("lk held a", issue_idx[3], 3); cyc();
        check("lk held b", issue_idx[3], 3);
        fu_ready = 4'b1000; cyc();
        check("lk next valid", issue_valid[3], 1);
        check("lk next idx", issue_idx[3], 1); cyc();
        check("lk done", issue_valid[3], 0);
        fu_ready = 4'b0000;

        // Full, ignored alloc, then flush dropping a simultaneous alloc.
        alloc(FU_ALU, 9, 0); check("full fill idx", alloc_idx, 1); cyc();
        alloc(FU_ALU, 9, 0); cyc();
        alloc(FU_ALU, 9, 0); cyc();
        check("full ready", alloc_ready, 0);
        check("full count", free_count, 0);
        alloc(FU_ALU, 0, 0); cyc();
        check("full ignored count", free_count, 0);
        check("full ignored issue", issue_valid[0], 0);
        alloc(FU_ALU, 0, 0); flush = 1; cyc();
        idle();
        check("flush free", free_count, 5);
        check("flush issue", issue_valid, 0);
        check("flush alloc_idx", alloc_idx, 0); cyc();
        check("flush no alloc", free_count, 5);

        // One ready entry per class, all accepted in the same cycle.
        alloc(FU_ALU, 0, 0); cyc();
        alloc(FU_LOAD, 0, 0); cyc();
        alloc(FU_STORE, 0, 0); cyc();
        alloc(FU_FP, 0, 0); cyc();
        idle();
        check("all valid", issue_valid, 4'b1111);
        check("all store idx", issue_idx[2], 2);
        fu_ready = 4'b1111; cyc();
        check("all freed", free_count, 5);
        check("all idle", issue_valid, 0);

        // Reset with a held lock and a pending entry.
        fu_ready = 4'b0000;
        alloc(FU_ALU, 0, 0); cyc();
        alloc(FU_FP, 9, 0); cyc();
        idle(); cyc();
        reset = 1; alloc(FU_LOAD, 0, 0); cyc();
        reset = 0; idle();
        check("mrst alloc_ready", alloc_ready, 1);
        check("mrst alloc_idx", alloc_idx, 0);
        check("mrst free_count", free_count, 5);
        check("mrst issue_valid", issue_valid, 0);
        check("mrst issue_idx", issue_idx, 0);
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
